// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the RV32I pipeline hazard/sequencing controller.
// Holds the FSM state encoding, forwarding-select encoding and the default load marker.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_ERR      = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_e;

  localparam logic [1:0] LOAD_SRC_DEFAULT = 2'b01;

  // M beats W because it holds the younger result; x0 is hardwired zero and never forwarded.
  function automatic fwd_sel_e fwd_select(
    input logic [4:0] rs,
    input logic [4:0] rd_m,
    input logic       rw_m,
    input logic [4:0] rd_w,
    input logic       rw_w
  );
    if (rw_m && (rd_m != 5'd0) && (rd_m == rs)) begin
      return FWD_MEM;
    end else if (rw_w && (rd_w != 5'd0) && (rd_w == rs)) begin
      return FWD_WB;
    end else begin
      return FWD_RF;
    end
  endfunction

endpackage

// File: rtl/pipe_perf_cnt.sv
// Free-running performance counters with individual increment enables.
// Counters wrap modulo 2^CNT_W and clear asynchronously on reset.
module pipe_perf_cnt #(
  parameter int CNT_W = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             cycle_en_i,
  input  logic             instret_en_i,
  input  logic             stall_en_i,
  output logic [CNT_W-1:0] cycle_cnt_o,
  output logic [CNT_W-1:0] instret_cnt_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  logic [CNT_W-1:0] cycle_q, cycle_d;
  logic [CNT_W-1:0] instret_q, instret_d;
  logic [CNT_W-1:0] stall_q, stall_d;

  always_comb begin
    cycle_d   = cycle_en_i   ? cycle_q   + CNT_W'(1) : cycle_q;
    instret_d = instret_en_i ? instret_q + CNT_W'(1) : instret_q;
    stall_d   = stall_en_i   ? stall_q   + CNT_W'(1) : stall_q;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cycle_q   <= '0;
      instret_q <= '0;
      stall_q   <= '0;
    end else begin
      cycle_q   <= cycle_d;
      instret_q <= instret_d;
      stall_q   <= stall_d;
    end
  end

  assign cycle_cnt_o   = cycle_q;
  assign instret_cnt_o = instret_q;
  assign stall_cnt_o   = stall_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Hazard and sequencing controller for the 5-stage RV32I pipeline: stall/flush
// generation, E-stage forwarding selects, LSU wait FSM with timeout trap, perf counters.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int         CNT_W       = 32,
  parameter int         TIMEOUT_CYC = 16,
  parameter logic [1:0] LOAD_SRC    = LOAD_SRC_DEFAULT
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [4:0]       i_rs1_addr_d,
  input  logic [4:0]       i_rs2_addr_d,
  input  logic [4:0]       i_rs1_addr_e,
  input  logic [4:0]       i_rs2_addr_e,
  input  logic [4:0]       i_rd_addr_e,
  input  logic             i_regwrite_e,
  input  logic [1:0]       i_resultsrc_e,
  input  logic [4:0]       i_rd_addr_m,
  input  logic [4:0]       i_rd_addr_w,
  input  logic             i_regwrite_m,
  input  logic             i_regwrite_w,
  input  logic             i_pc_src_e,
  input  logic             i_lsu_req_m,
  input  logic             i_lsu_ack,
  input  logic             i_insn_vld_w,
  output logic             o_stall_f,
  output logic             o_stall_d,
  output logic             o_stall_e,
  output logic             o_stall_m,
  output logic             o_flush_d,
  output logic             o_flush_e,
  output logic             o_flush_w,
  output logic [1:0]       o_fwd_a_e,
  output logic [1:0]       o_fwd_b_e,
  output logic [1:0]       o_state,
  output logic             o_mem_err,
  output logic [CNT_W-1:0] o_cycle_cnt,
  output logic [CNT_W-1:0] o_instret_cnt,
  output logic [CNT_W-1:0] o_stall_cnt
);

  localparam logic [1:0] S_RUN      = ST_RUN;
  localparam logic [1:0] S_MEM_WAIT = ST_MEM_WAIT;
  localparam logic [1:0] S_ERR      = ST_ERR;

  localparam int                WAIT_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [WAIT_W-1:0] TIMEOUT_V = WAIT_W'(TIMEOUT_CYC);

  logic [1:0]        state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [WAIT_W-1:0] wait_inc;
  logic              err_q, err_d;
  logic              freeze;
  logic              hold_all;
  logic              load_use;

  // LSU handshake: i_lsu_req_m stays high while M owns an outstanding access;
  // i_lsu_ack is a one-cycle completion pulse, and the access finishes in that cycle.
  assign freeze = ((state_q == S_RUN) && i_lsu_req_m && !i_lsu_ack) ||
                  ((state_q == S_MEM_WAIT) && !i_lsu_ack);
  assign hold_all = (state_q == S_ERR) || freeze;
  assign wait_inc = wait_cnt_q + WAIT_W'(1);

  assign load_use = i_regwrite_e && (i_resultsrc_e == LOAD_SRC) && (i_rd_addr_e != 5'd0) &&
                    ((i_rd_addr_e == i_rs1_addr_d) || (i_rd_addr_e == i_rs2_addr_d));

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    err_d      = err_q;
    case (state_q)
      S_RUN: begin
        if (freeze) begin
          if (TIMEOUT_CYC <= 1) begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end else begin
            state_d = S_MEM_WAIT;
          end
          wait_cnt_d = WAIT_W'(1);
        end
      end
      S_MEM_WAIT: begin
        if (i_lsu_ack) begin
          state_d    = S_RUN;
          wait_cnt_d = '0;
        end else begin
          wait_cnt_d = wait_inc;
          if (wait_inc == TIMEOUT_V) begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end
        end
      end
      S_ERR: begin
        state_d = S_ERR;
      end
      default: begin
        state_d    = S_RUN;
        wait_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= S_RUN;
      wait_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      err_q      <= err_d;
    end
  end

  // A redirect seen while frozen is simply re-presented by the held E stage on release.
  always_comb begin
    o_stall_f = 1'b0;
    o_stall_d = 1'b0;
    o_stall_e = 1'b0;
    o_stall_m = 1'b0;
    o_flush_d = 1'b0;
    o_flush_e = 1'b0;
    o_flush_w = 1'b0;
    if (hold_all) begin
      o_stall_f = 1'b1;
      o_stall_d = 1'b1;
      o_stall_e = 1'b1;
      o_stall_m = 1'b1;
      o_flush_w = 1'b1;
    end else if (i_pc_src_e) begin
      o_flush_d = 1'b1;
      o_flush_e = 1'b1;
    end else if (load_use) begin
      o_stall_f = 1'b1;
      o_stall_d = 1'b1;
      o_flush_e = 1'b1;
    end
  end

  assign o_fwd_a_e = fwd_select(i_rs1_addr_e, i_rd_addr_m, i_regwrite_m, i_rd_addr_w, i_regwrite_w);
  assign o_fwd_b_e = fwd_select(i_rs2_addr_e, i_rd_addr_m, i_regwrite_m, i_rd_addr_w, i_regwrite_w);

  assign o_state   = state_q;
  assign o_mem_err = err_q;

  pipe_perf_cnt #(
    .CNT_W(CNT_W)
  ) u_perf_cnt (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .cycle_en_i   (1'b1),
    .instret_en_i (i_insn_vld_w && !o_flush_w),
    .stall_en_i   (o_stall_f),
    .cycle_cnt_o  (o_cycle_cnt),
    .instret_cnt_o(o_instret_cnt),
    .stall_cnt_o  (o_stall_cnt)
  );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: a vector table for combinational hazard/forwarding
// behaviour plus hand-written sequences for LSU wait, timeout, counters and reset.
module tb_pipe_ctrl;

  localparam int CNT_W = 4;
  localparam int TMO   = 4;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
  logic       rw_e, rw_m, rw_w, pc_src, lsu_req, lsu_ack, insn_vld_w;
  logic [1:0] rsrc;

  logic stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w;
  logic [1:0] fwd_a, fwd_b, state;
  logic       mem_err;
  logic [CNT_W-1:0] cycle_cnt, instret_cnt, stall_cnt;

  pipe_ctrl #(
    .CNT_W      (CNT_W),
    .TIMEOUT_CYC(TMO),
    .LOAD_SRC   (2'b01)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_rs1_addr_d (rs1_d),
    .i_rs2_addr_d (rs2_d),
    .i_rs1_addr_e (rs1_e),
    .i_rs2_addr_e (rs2_e),
    .i_rd_addr_e  (rd_e),
    .i_regwrite_e (rw_e),
    .i_resultsrc_e(rsrc),
    .i_rd_addr_m  (rd_m),
    .i_rd_addr_w  (rd_w),
    .i_regwrite_m (rw_m),
    .i_regwrite_w (rw_w),
    .i_pc_src_e   (pc_src),
    .i_lsu_req_m  (lsu_req),
    .i_lsu_ack    (lsu_ack),
    .i_insn_vld_w (insn_vld_w),
    .o_stall_f    (stall_f),
    .o_stall_d    (stall_d),
    .o_stall_e    (stall_e),
    .o_stall_m    (stall_m),
    .o_flush_d    (flush_d),
    .o_flush_e    (flush_e),
    .o_flush_w    (flush_w),
    .o_fwd_a_e    (fwd_a),
    .o_fwd_b_e    (fwd_b),
    .o_state      (state),
    .o_mem_err    (mem_err),
    .o_cycle_cnt  (cycle_cnt),
    .o_instret_cnt(instret_cnt),
    .o_stall_cnt  (stall_cnt)
  );

  // ctl packing: {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w}
  typedef struct {
    string      name;
    logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
    logic       rw_e, rw_m, rw_w, pc_src, lsu_req, lsu_ack;
    logic [1:0] rsrc;
    logic [6:0] exp_ctl;
    logic [1:0] exp_a, exp_b;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;
  logic [CNT_W-1:0] s0, i0, c0, e_cnt;

  function automatic vec_t mk(input string name,
                              input logic [4:0] r1d, r2d, r1e, r2e, rde,
                              input logic we, input logic [1:0] rs,
                              input logic [4:0] rdm, input logic wm,
                              input logic [4:0] rdw, input logic ww,
                              input logic pcs, req, ack,
                              input logic [6:0] ctl, input logic [1:0] ea, eb);
    vec_t v;
    v.name = name;
    v.rs1_d = r1d; v.rs2_d = r2d; v.rs1_e = r1e; v.rs2_e = r2e; v.rd_e = rde;
    v.rw_e = we; v.rsrc = rs; v.rd_m = rdm; v.rw_m = wm; v.rd_w = rdw; v.rw_w = ww;
    v.pc_src = pcs; v.lsu_req = req; v.lsu_ack = ack;
    v.exp_ctl = ctl; v.exp_a = ea; v.exp_b = eb;
    return v;
  endfunction

  // scoreboard compare
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [6:0] ctl_now();
    return {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w};
  endfunction

  // driver tasks
  task automatic drive_idle();
    rs1_d = 0; rs2_d = 0; rs1_e = 0; rs2_e = 0; rd_e = 0; rd_m = 0; rd_w = 0;
    rw_e = 0; rw_m = 0; rw_w = 0; rsrc = 0; pc_src = 0; lsu_req = 0; lsu_ack = 0;
    insn_vld_w = 0;
  endtask

  task automatic drive_vec(input vec_t v);
    rs1_d = v.rs1_d; rs2_d = v.rs2_d; rs1_e = v.rs1_e; rs2_e = v.rs2_e; rd_e = v.rd_e;
    rw_e = v.rw_e; rsrc = v.rsrc; rd_m = v.rd_m; rw_m = v.rw_m; rd_w = v.rd_w; rw_w = v.rw_w;
    pc_src = v.pc_src; lsu_req = v.lsu_req; lsu_ack = v.lsu_ack;
  endtask

  initial begin
    drive_idle();

    //                name           r1d r2d r1e r2e rde we rsrc  rdm wm rdw ww pc rq ak ctl         a      b
    vecs.push_back(mk("idle",        0,  0,  0,  0,  0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 7'b0000000, 2'b00, 2'b00));
    vecs.push_back(mk("fwd_m_prio",  0,  0,  5,  0,  0, 0, 2'b00, 5, 1, 5, 1, 0, 0, 0, 7'b0000000, 2'b10, 2'b00));
    vecs.push_back(mk("fwd_w_rdm0",  0,  0,  5,  0,  0, 0, 2'b00, 0, 1, 5, 1, 0, 0, 0, 7'b0000000, 2'b01, 2'b00));
    vecs.push_back(mk("fwd_b_w",     0,  0,  1,  5,  0, 0, 2'b00, 5, 0, 5, 1, 0, 0, 0, 7'b0000000, 2'b00, 2'b01));
    vecs.push_back(mk("fwd_b_m",     0,  0,  9,  9,  0, 0, 2'b00, 9, 1, 3, 1, 0, 0, 0, 7'b0000000, 2'b10, 2'b10));
    vecs.push_back(mk("fwd_x0",      0,  0,  0,  0,  0, 0, 2'b00, 0, 1, 0, 1, 0, 0, 0, 7'b0000000, 2'b00, 2'b00));
    vecs.push_back(mk("lu_rs2",      0,  7,  0,  0,  7, 1, 2'b01, 0, 0, 0, 0, 0, 0, 0, 7'b1100010, 2'b00, 2'b00));
    vecs.push_back(mk("lu_rs1",      7,  3,  0,  0,  7, 1, 2'b01, 0, 0, 0, 0, 0, 0, 0, 7'b1100010, 2'b00, 2'b00));
    vecs.push_back(mk("lu_rd0",      0,  0,  0,  0,  0, 1, 2'b01, 0, 0, 0, 0, 0, 0, 0, 7'b0000000, 2'b00, 2'b00));
    vecs.push_back(mk("lu_not_load", 0,  7,  0,  0,  7, 1, 2'b00, 0, 0, 0, 0, 0, 0, 0, 7'b0000000, 2'b00, 2'b00));
    vecs.push_back(mk("lu_no_wr",    0,  7,  0,  0,  7, 0, 2'b01, 0, 0, 0, 0, 0, 0, 0, 7'b0000000, 2'b00, 2'b00));
    vecs.push_back(mk("lu_no_match", 4,  6,  0,  0,  7, 1, 2'b01, 0, 0, 0, 0, 0, 0, 0, 7'b0000000, 2'b00, 2'b00));
    vecs.push_back(mk("redir_vs_lu", 0,  7,  0,  0,  7, 1, 2'b01, 0, 0, 0, 0, 1, 0, 0, 7'b0000110, 2'b00, 2'b00));
    vecs.push_back(mk("redir",       0,  0,  0,  0,  0, 0, 2'b00, 0, 0, 0, 0, 1, 0, 0, 7'b0000110, 2'b00, 2'b00));
    vecs.push_back(mk("req_ack_run", 0,  0,  0,  0,  0, 0, 2'b00, 0, 0, 0, 0, 0, 1, 1, 7'b0000000, 2'b00, 2'b00));

    // reset state, observed while reset is held
    repeat (2) @(negedge clk);
    #1;
    check("rst_state",   32'(state), 32'd0);
    check("rst_mem_err", 32'(mem_err), 32'd0);
    check("rst_ctl",     32'(ctl_now()), 32'd0);
    check("rst_cycle",   32'(cycle_cnt), 32'd0);
    check("rst_instret", 32'(instret_cnt), 32'd0);
    check("rst_stall",   32'(stall_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // vector table
    foreach (vecs[i]) begin
      @(negedge clk);
      drive_vec(vecs[i]);
      #1;
      check({vecs[i].name, "_ctl"},   32'(ctl_now()), 32'(vecs[i].exp_ctl));
      check({vecs[i].name, "_fwd_a"}, 32'(fwd_a), 32'(vecs[i].exp_a));
      check({vecs[i].name, "_fwd_b"}, 32'(fwd_b), 32'(vecs[i].exp_b));
      check({vecs[i].name, "_state"}, 32'(state), 32'd0);
    end

    // load-use lasts one cycle and bumps the stall counter once
    @(negedge clk);
    drive_idle();
    #1;
    s0 = stall_cnt;
    @(negedge clk);
    drive_vec(vecs[6]);
    #1;
    check("lu_seq_ctl", 32'(ctl_now()), 32'b1100010);
    @(negedge clk);
    drive_idle();
    #1;
    check("lu_seq_release", 32'(ctl_now()), 32'd0);
    e_cnt = s0 + 4'd1;
    check("lu_seq_stall_cnt", 32'(stall_cnt), 32'(e_cnt));

    // LSU wait: 3 un-acked cycles, redirect held during freeze, taken on ack cycle
    @(negedge clk);
    lsu_req = 1; lsu_ack = 0; insn_vld_w = 1;
    #1;
    s0 = stall_cnt; i0 = instret_cnt;
    check("wait0_ctl", 32'(ctl_now()), 32'b1111001);
    check("wait0_state", 32'(state), 32'd0);
    for (int k = 1; k <= 2; k++) begin
      @(negedge clk);
      pc_src = 1;
      #1;
      check("waitN_ctl", 32'(ctl_now()), 32'b1111001);
      check("waitN_state", 32'(state), 32'd1);
      check("waitN_instret", 32'(instret_cnt), 32'(i0));
    end
    @(negedge clk);
    lsu_ack = 1;
    #1;
    check("wait_ack_ctl", 32'(ctl_now()), 32'b0000110);
    @(negedge clk);
    drive_idle();
    #1;
    check("wait_done_state", 32'(state), 32'd0);
    check("wait_done_ctl", 32'(ctl_now()), 32'd0);
    e_cnt = i0 + 4'd1;
    check("wait_instret", 32'(instret_cnt), 32'(e_cnt));
    e_cnt = s0 + 4'd3;
    check("wait_stall_cnt", 32'(stall_cnt), 32'(e_cnt));

    // timeout into ERR after TMO un-acked cycles
    for (int k = 0; k < TMO; k++) begin
      @(negedge clk);
      lsu_req = 1; lsu_ack = 0;
      #1;
      check("tmo_state", 32'(state), (k == 0) ? 32'd0 : 32'd1);
      check("tmo_mem_err", 32'(mem_err), 32'd0);
    end
    @(negedge clk);
    lsu_req = 0; lsu_ack = 1; pc_src = 1;
    #1;
    c0 = cycle_cnt; s0 = stall_cnt;
    check("err_state", 32'(state), 32'd2);
    check("err_mem_err", 32'(mem_err), 32'd1);
    check("err_ctl", 32'(ctl_now()), 32'b1111001);
    repeat (3) @(negedge clk);
    #1;
    check("err_hold_state", 32'(state), 32'd2);
    check("err_hold_ctl", 32'(ctl_now()), 32'b1111001);
    e_cnt = c0 + 4'd3;
    check("err_cycle_cnt", 32'(cycle_cnt), 32'(e_cnt));
    e_cnt = s0 + 4'd3;
    check("err_stall_cnt", 32'(stall_cnt), 32'(e_cnt));
    #1 rst_n = 1'b0;
    #1;
    check("err_rst_state", 32'(state), 32'd0);
    check("err_rst_mem_err", 32'(mem_err), 32'd0);
    @(negedge clk);
    drive_idle();
    rst_n = 1'b1;

    // async reset mid MEM_WAIT, then 17 cycles wraps the 4-bit cycle counter to 1
    @(negedge clk);
    lsu_req = 1;
    @(negedge clk);
    #1;
    check("mw_pre_rst_state", 32'(state), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("mw_rst_state", 32'(state), 32'd0);
    check("mw_rst_cycle", 32'(cycle_cnt), 32'd0);
    check("mw_rst_instret", 32'(instret_cnt), 32'd0);
    check("mw_rst_stall", 32'(stall_cnt), 32'd0);
    @(negedge clk);
    drive_idle();
    rst_n = 1'b1;
    repeat (17) @(negedge clk);
    #1;
    check("wrap_cycle", 32'(cycle_cnt), 32'd1);
    check("wrap_state", 32'(state), 32'd0);

    // final report
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
